// File: rtl/mux_scan_pkg.sv
// Shared types for the mux select scanner: FSM states, channel count, select index.
// Combinational definitions only; no latency or flow control of its own.
package mux_scan_pkg;
  localparam int N_CH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request after 'last', wrapping 3->0; zero latency.
// Purely combinational; 'any' is low when no channel requests.
module rr_pick
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            last,
  output sel_t            grant,
  output logic            any
);

  sel_t idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = last;
    any   = 1'b0;
    idx   = last;
    for (int i = N_CH; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_select_scanner.sv
// Scans requesting mux inputs round-robin; valid rises DWELL cycles after select changes.
// Holds select and valid until ack or TIMEOUT cycles pass, then flags sticky err.
module mux_select_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  input  logic            ack,
  output logic            s1,
  output logic            s0,
  output logic            valid,
  output logic            err
);

  localparam logic [3:0] DWELL_LD = 4'(DWELL - 1);
  localparam logic [7:0] TMO_LD   = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  sel_t       sel_q, sel_d;
  sel_t       last_q, last_d;
  logic [3:0] dwell_q, dwell_d;
  logic [7:0] tmo_q, tmo_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  sel_t       grant;
  logic       any;

  rr_pick u_rr_pick (
    .req   (req),
    .last  (last_q),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    tmo_d   = tmo_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (en && any) begin
          sel_d   = grant;
          dwell_d = DWELL_LD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Abort leaves last untouched so the same channel is granted again.
        if (!en) begin
          state_d = IDLE;
        end else if (dwell_q == 4'd0) begin
          valid_d = 1'b1;
          tmo_d   = TMO_LD;
          state_d = WAIT_ACK;
        end else begin
          dwell_d = dwell_q - 4'd1;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          valid_d = 1'b0;
          last_d  = sel_q;
          state_d = IDLE;
        end else if (tmo_q == 8'd0) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          last_d  = sel_q;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      dwell_q <= 4'd0;
      tmo_q   <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mux_select_scanner.sv
// Bench for mux_select_scanner: directed scenarios plus random traffic against an age-based model.
module tb_mux_select_scanner;
  localparam int DWELL   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] req = 4'd0;
  logic       s1, s0, valid, err;

  int checks = 0;
  int errors = 0;

  // Model: a grant is "busy" for some number of edges ("age"); valid once age reaches DWELL.
  bit m_busy  = 1'b0;
  int m_sel   = 0;
  int m_last  = 3;
  int m_age   = 0;
  bit m_err   = 1'b0;
  bit m_found = 1'b0;

  mux_select_scanner #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .ack   (ack),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_sel = 0; m_last = 3; m_age = 0; m_err = 1'b0;
    end else if (!m_busy) begin
      if (en && req != 4'd0) begin
        m_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          if (!m_found && req[(m_last + i) % 4]) begin
            m_sel   = (m_last + i) % 4;
            m_found = 1'b1;
          end
        end
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else if (m_age < DWELL) begin
      if (!en) m_busy = 1'b0;
      else     m_age  = m_age + 1;
    end else begin
      if (ack) begin
        m_busy = 1'b0; m_last = m_sel;
      end else if (m_age - DWELL == TIMEOUT - 1) begin
        m_busy = 1'b0; m_err = 1'b1; m_last = m_sel;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  task automatic tick();
    bit ev;
    @(posedge clk);
    #1;
    ev = m_busy && (m_age >= DWELL);
    checks++;
    if ({s1, s0} !== 2'(m_sel) || valid !== ev || err !== m_err) begin
      errors++;
      $display("FAIL model t=%0t sel=%0d want %0d valid=%0b want %0b err=%0b want %0b",
               $time, {s1, s0}, m_sel, valid, ev, err, m_err);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic grant_one(input bit do_ack, output int g);
    int n;
    wait_valid(n);
    chk("valid_seen", int'(valid), 1);
    g = int'({s1, s0});
    if (do_ack) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, g;
    bit seen;

    // Reset state and first-grant latency.
    tick();
    chk("reset_valid", int'(valid), 0);
    chk("reset_sel", int'({s1, s0}), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b0; en = 1'b1; req = 4'b0001;
    tick();
    chk("first_sel", int'({s1, s0}), 0);
    chk("first_valid_low", int'(valid), 0);
    wait_valid(n);
    chk("latency", n, DWELL);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_drops_valid", int'(valid), 0);

    // Round robin with all channels requesting, then alternate channels only.
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      grant_one(1'b1, g);
      chk("rr_order", g, k % 4);
    end
    chk("rr_err", int'(err), 0);
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      grant_one(1'b1, g);
      chk("rr_1010", g, (k % 2 == 1) ? 3 : 1);
    end

    // Enable dropped mid-dwell: abort, and the same channel is granted again.
    req = 4'b1111;
    tick();
    chk("abort_grant", int'({s1, s0}), 0);
    tick(); tick();
    en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid) seen = 1'b1;
    end
    chk("abort_no_valid", int'(seen), 0);
    en = 1'b1;
    grant_one(1'b1, g);
    chk("abort_same_ch", g, 0);

    // Ack timeout: valid for exactly TIMEOUT cycles, sticky err, pointer advances.
    grant_one(1'b0, g);
    chk("tmo_grant", g, 1);
    n = 0;
    while (valid === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_valid_len", n, TIMEOUT);
    chk("tmo_err", int'(err), 1);
    tick(); tick(); tick();
    grant_one(1'b1, g);
    chk("tmo_next_grant", g, 2);
    chk("err_sticky", int'(err), 1);

    // Asynchronous reset between edges while waiting for ack.
    grant_one(1'b0, g);
    chk("pre_rst_sel", g, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_sel", int'({s1, s0}), 0);
    chk("async_err", int'(err), 0);
    #1 rst = 1'b0;
    grant_one(1'b1, g);
    chk("post_rst_grant", g, 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      req = 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_select_scanner.md
MUX_SELECT_SCANNER -- requirements
Module: mux_select_scanner

Interface
REQ-001 Parameters: DWELL, 4, mux settle cycles between select change and valid (legal range 1..15).
REQ-002 Parameters: TIMEOUT, 16, max cycles valid waits for ack (legal range 1..255).
REQ-003 Ports: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Ports: rst  input  1  reset; asynchronous, active-high.
REQ-005 Ports: en  input  1  scanner enable.
REQ-006 Ports: req  input  4  per-channel request, bit n = mux input in n.
REQ-007 Ports: ack  input  1  downstream consumed the sampled mux output.
REQ-008 Ports: s1, s0  output  1 each  registered select to downstream 4:1 mux; {s1,s0} = granted channel index.
REQ-009 Ports: valid  output  1  mux output settled and sampleable.
REQ-010 Ports: err  output  1  sticky ack-timeout flag.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, HOLD and WAIT_ACK.
REQ-012 IDLE, en=1 and req!=0: grant the first set req bit searching last+1, last+2, ... mod 4; register {s1,s0}=grant; load dwell counter with DWELL-1; go to HOLD.
REQ-013 IDLE, en=0 or req=0: hold {s1,s0}; valid=0.
REQ-014 HOLD: decrement dwell counter each cycle; at the edge where it is 0, set valid=1, load timeout counter with TIMEOUT-1, go to WAIT_ACK.
REQ-015 Latency: valid rises exactly DWELL cycles after the edge that updates {s1,s0}.
REQ-016 HOLD, en=0: abort to IDLE next edge; valid stays 0; last pointer unchanged.
REQ-017 Request deassertion during HOLD or WAIT_ACK SHALL NOT affect the current grant.
REQ-018 WAIT_ACK: valid held at 1 and {s1,s0} held stable regardless of en.
REQ-019 WAIT_ACK, ack=1: valid=0; last=grant; go to IDLE.
REQ-020 WAIT_ACK, ack=0 and timeout counter 0: valid=0; err=1; last=grant; go to IDLE.
REQ-021 WAIT_ACK, ack=0 and timeout counter non-zero: decrement the timeout counter.
REQ-022 Ack and timeout expiry in the same cycle: ack wins; err unchanged.
REQ-023 ack while valid=0 SHALL be ignored.
REQ-024 err, once set, SHALL clear only on reset.
REQ-025 One IDLE cycle minimum between consecutive grants; round-robin wrap 3->0.

Reset
REQ-026 On rst assertion, without waiting for clk: state=IDLE, s1=0, s0=0, valid=0, err=0, last=3, both counters 0.
REQ-027 On rst release: first grant priority order is 0,1,2,3.
REQ-028 rst asserted mid-HOLD or mid-WAIT_ACK SHALL drop valid and select immediately; no ack is required.

Structure
REQ-029 Shared package mux_scan_pkg SHALL hold the state enum, N_CH=4, and the select index typedef (2 bits).
REQ-030 Sub-module rr_pick SHALL be combinational: (req[3:0], last[1:0]) -> (grant[1:0], any).
REQ-031 All outputs SHALL be driven from flops.

Verification
REQ-032 Reset, en=1, req=0001, ack tied 0 until valid: {s1,s0}=00 one edge after reset release; valid=1 exactly 4 cycles later.
REQ-033 req=1111 held, ack pulsed one cycle after each valid: grant order 0,1,2,3,0; err=0.
REQ-034 After grant 3, req=1010: grants 1 then 3; 0 and 2 never selected.
REQ-035 en dropped 2 cycles into HOLD: valid never rises; IDLE next edge; next grant is the same channel.
REQ-036 ack held 0 with TIMEOUT=16: valid high exactly 16 cycles, then 0; err=1 and stays 1; next grant advances pointer.
REQ-037 rst pulsed mid-WAIT_ACK between clock edges: valid, s1, s0, err read 0 before the next clk edge.
